// File: rtl/noise_cdf_sampler_if.sv
// Sampler bus bundle: uniform-word input stream, memory port-2 read bus and
// noise-sample output stream.
//   u_*   : uniform word handshake (u_valid/u_data in, u_ready out of the sampler)
//   mem_* : 64-bit, 14-bit-address memory port (sampler is a read-only client)
//   s_*   : sample handshake (s_valid/s_index/s_noise out, s_ready in)
// Modport master is the sampler side; slave is the PRNG / memory / adder side.
interface noise_cdf_sampler_if #(
    parameter int unsigned TABLE_LOG2 = 13
);
    logic                  u_valid;
    logic                  u_ready;
    logic [63:0]           u_data;
    logic [13:0]           mem_address;
    logic                  mem_chipselect;
    logic                  mem_write;
    logic [7:0]            mem_byteenable;
    logic [63:0]           mem_writedata;
    logic                  mem_clken;
    logic [63:0]           mem_readdata;
    logic                  s_valid;
    logic                  s_ready;
    logic [TABLE_LOG2-1:0] s_index;
    logic [TABLE_LOG2:0]   s_noise;

    modport master (
        input  u_valid, u_data, mem_readdata, s_ready,
        output u_ready, mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_writedata, mem_clken, s_valid, s_index, s_noise
    );

    modport slave (
        output u_valid, u_data, mem_readdata, s_ready,
        input  u_ready, mem_address, mem_chipselect, mem_write, mem_byteenable,
               mem_writedata, mem_clken, s_valid, s_index, s_noise
    );
endinterface

// File: rtl/noise_cdf_sampler.sv
// Inverse-CDF noise sampler. Takes a 64-bit uniform word, binary-searches the
// CDF table on memory port 2 (one probe per result bit, MSB first) and emits
// the table index plus the signed noise value index - CENTER.
// Ports:
//   i_clk      system clock (also the memory port-2 clock)
//   i_reset_n  asynchronous active-low reset
//   sif        master side of noise_cdf_sampler_if (u_*, mem_*, s_*)
//   o_busy     high while a search is running (issue/wait states)
module noise_cdf_sampler #(
    parameter int unsigned TABLE_LOG2 = 13,
    parameter logic [13:0] TABLE_BASE = 14'd0,
    parameter int unsigned CENTER     = 4096
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    noise_cdf_sampler_if.master        sif,
    output logic                       o_busy
);
    localparam int unsigned BW = (TABLE_LOG2 > 1) ? $clog2(TABLE_LOG2) : 1;
    localparam logic [TABLE_LOG2:0] C_CENTER = (TABLE_LOG2+1)'(CENTER);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SEARCH_ISSUE = 2'd1,
        SEARCH_WAIT  = 2'd2,
        OUT          = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [63:0]           r_u;
    logic [TABLE_LOG2-1:0] r_res;
    logic [TABLE_LOG2-1:0] r_index;
    logic [BW-1:0]         r_bit;
    logic                  r_live;

    logic [TABLE_LOG2-1:0] w_cand;
    logic [13:0]           w_probe_addr;
    logic                  w_hit;
    logic                  w_last_bit;
    logic                  w_accept;
    logic                  w_u_ready;
    logic                  w_cs;
    logic [13:0]           w_addr;
    logic                  w_s_valid;
    logic                  w_busy;

    // Candidate keeps the bits already decided and tries the current one.
    // Probing entry cand-1 decides whether at least cand entries are <= u,
    // so cand >= 1 always and the highest address probed is BASE+DEPTH-2.
    assign w_cand       = r_res | (TABLE_LOG2'(1) << r_bit);
    assign w_probe_addr = TABLE_BASE + 14'(w_cand) - 14'd1;
    assign w_hit        = (sif.mem_readdata <= r_u);
    assign w_last_bit   = (r_bit == '0);

    // r_live keeps u_ready low until the first clock after reset release.
    assign w_accept     = (r_state == IDLE) && r_live && sif.u_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_u_ready   = 1'b0;
        w_cs        = 1'b0;
        w_addr      = TABLE_BASE;
        w_s_valid   = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_u_ready = r_live;
                if (w_accept) begin
                    w_state_nxt = SEARCH_ISSUE;
                end
            end
            SEARCH_ISSUE: begin
                w_cs        = 1'b1;
                w_addr      = w_probe_addr;
                w_busy      = 1'b1;
                w_state_nxt = SEARCH_WAIT;
            end
            SEARCH_WAIT: begin
                w_busy      = 1'b1;
                w_state_nxt = w_last_bit ? OUT : SEARCH_ISSUE;
            end
            OUT: begin
                w_s_valid = 1'b1;
                if (sif.s_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_u     <= '0;
            r_res   <= '0;
            r_bit   <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_u   <= sif.u_data;
                        r_res <= '0;
                        r_bit <= BW'(TABLE_LOG2 - 1);
                    end
                end
                SEARCH_WAIT: begin
                    // r_res is unchanged since the issue cycle, so w_cand is
                    // the same candidate that was addressed.
                    if (w_hit) begin
                        r_res <= w_cand;
                    end
                    if (w_last_bit) begin
                        r_index <= w_hit ? w_cand : r_res;
                    end else begin
                        r_bit <= r_bit - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sif.u_ready        = w_u_ready;
    assign sif.mem_address    = w_addr;
    assign sif.mem_chipselect = w_cs;
    assign sif.mem_write      = 1'b0;
    assign sif.mem_byteenable = 8'hFF;
    assign sif.mem_writedata  = 64'd0;
    assign sif.mem_clken      = 1'b1;
    assign sif.s_valid        = w_s_valid;
    assign sif.s_index        = r_index;
    // Zero-extend, subtract, wrap in TABLE_LOG2+1 bits.
    assign sif.s_noise        = {1'b0, r_index} - C_CENTER;
    assign o_busy             = w_busy;
endmodule

// File: tb/tb_noise_cdf_sampler.sv
module tb_noise_cdf_sampler;
    localparam int unsigned L    = 3;
    localparam int unsigned C    = 4;
    localparam logic [13:0] BASE = 14'd100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   bad_addr = 0;
    int   wr_seen = 0;
    logic [13:0] rd_q[$];
    logic [63:0] cdf [8];

    always #5 clk = ~clk;

    noise_cdf_sampler_if #(.TABLE_LOG2(L)) sif ();

    noise_cdf_sampler #(.TABLE_LOG2(L), .TABLE_BASE(BASE), .CENTER(C)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .sif      (sif.master),
        .o_busy   (busy)
    );

    // One-cycle-latency memory model plus bus monitor.
    always @(posedge clk) begin
        int ai;
        cyc <= cyc + 1;
        if (sif.mem_write !== 1'b0) wr_seen++;
        if (sif.mem_chipselect === 1'b1) begin
            rd_q.push_back(sif.mem_address);
            ai = int'(sif.mem_address) - int'(BASE);
            if (ai < 0 || ai > 6) bad_addr++;
            if (ai >= 0 && ai <= 7) sif.mem_readdata <= cdf[ai];
            else sif.mem_readdata <= 'x;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count of table entries 0..DEPTH-2 that are <= u.
    function automatic int ref_index(input logic [63:0] u);
        int n = 0;
        for (int k = 0; k < 7; k++) if (cdf[k] <= u) n++;
        return n;
    endfunction

    // Drives one request and waits for its sample; lat counts clock edges
    // from the accepting edge to the first cycle with s_valid.
    task automatic do_req(input logic [63:0] u, input bit hs, output int lat,
                          output logic [L-1:0] idx, output logic [L:0] nz, output bit ok);
        ok = 0; lat = 0; idx = '0; nz = '0;
        for (int i = 0; i < 30 && sif.u_ready !== 1'b1; i++) tick();
        if (sif.u_ready !== 1'b1) return;
        sif.u_data  = u;
        sif.u_valid = 1'b1;
        tick();
        sif.u_valid = 1'b0;
        lat = 1;
        while (sif.s_valid !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        if (sif.s_valid !== 1'b1) return;
        ok  = 1;
        idx = sif.s_index;
        nz  = sif.s_noise;
        if (hs) begin
            sif.s_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        sif.u_valid = 1'b0; sif.u_data = '0; sif.s_ready = 1'b0; sif.mem_readdata = '0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sif.u_ready, sif.s_valid, sif.mem_chipselect, busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {sif.u_ready, sif.s_valid, sif.mem_chipselect, busy});
        end
        n_cmp++;
        if (sif.s_index !== 3'd0 || sif.s_noise !== 4'hC) begin
            n_bad++; $display("FAIL reset_sample: got idx %0d noise %h want 0 / c", sif.s_index, sif.s_noise);
        end
        n_cmp++;
        if (sif.mem_address !== BASE) begin
            n_bad++; $display("FAIL reset_addr: got %0d want %0d", sif.mem_address, BASE);
        end
        n_cmp++;
        if ({sif.mem_write, sif.mem_byteenable, sif.mem_writedata, sif.mem_clken} !== {1'b0, 8'hFF, 64'd0, 1'b1}) begin
            n_bad++; $display("FAIL const_outputs: got %b %h %h %b want 0 ff 0 1", sif.mem_write, sif.mem_byteenable, sif.mem_writedata, sif.mem_clken);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (sif.u_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_reset: got %b want 1", sif.u_ready);
        end
    endtask

    task automatic test_basic();
        int lat; logic [L-1:0] idx; logic [L:0] nz; bit ok;
        rd_q.delete();
        do_req(64'd0, 1'b1, lat, idx, nz, ok);
        n_cmp++;
        if (!ok || idx !== 3'd0 || nz !== 4'hC) begin
            n_bad++; $display("FAIL u0_result: got ok %0d idx %0d noise %h want 1 0 c", ok, idx, nz);
        end
        n_cmp++;
        if (lat != 7) begin
            n_bad++; $display("FAIL u0_latency: got %0d want 7", lat);
        end
        n_cmp++;
        if (rd_q.size() != 3 || rd_q[0] !== 14'd103 || rd_q[1] !== 14'd101 || rd_q[2] !== 14'd100) begin
            n_bad++; $display("FAIL u0_reads: got %0d reads %p want 103 101 100", rd_q.size(), rd_q);
        end
    endtask

    task automatic test_values();
        logic [63:0] uv [6];
        int          ev [6];
        int lat; logic [L-1:0] idx; logic [L:0] nz; bit ok;
        uv[0] = 64'd35; ev[0] = 3;
        uv[1] = 64'd10; ev[1] = 1;
        uv[2] = 64'd70; ev[2] = 7;
        uv[3] = 64'hFFFF_FFFF_FFFF_FFFF; ev[3] = 7;
        uv[4] = 64'd9;  ev[4] = 0;
        uv[5] = 64'd69; ev[5] = 6;
        for (int i = 0; i < 6; i++) begin
            do_req(uv[i], 1'b1, lat, idx, nz, ok);
            n_cmp++;
            if (!ok || int'(idx) != ev[i] || int'($signed(nz)) != ev[i] - int'(C)) begin
                n_bad++; $display("FAIL value_%0d: got ok %0d idx %0d noise %0d want idx %0d noise %0d",
                                  i, ok, idx, $signed(nz), ev[i], ev[i] - int'(C));
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [L-1:0] idx; logic [L:0] nz; bit ok; int n0;
        sif.s_ready = 1'b0;
        rd_q.delete();
        do_req(64'd50, 1'b0, lat, idx, nz, ok);
        n_cmp++;
        if (!ok || idx !== 3'd5) begin
            n_bad++; $display("FAIL bp_result: got ok %0d idx %0d want 5", ok, idx);
        end
        n0 = rd_q.size();
        sif.u_valid = 1'b1; sif.u_data = 64'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (sif.s_valid !== 1'b1 || sif.s_index !== 3'd5 || sif.u_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold_%0d: got valid %b idx %0d ready %b want 1 5 0", i, sif.s_valid, sif.s_index, sif.u_ready);
            end
        end
        sif.u_valid = 1'b0;
        n_cmp++;
        if (rd_q.size() != n0 || n0 != 3) begin
            n_bad++; $display("FAIL bp_reads: got %0d then %0d want 3 then 3", n0, rd_q.size());
        end
        sif.s_ready = 1'b1;
        #1;
        n_cmp++;
        if (sif.u_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_ready_in_out: got %b want 0", sif.u_ready);
        end
        tick();
        n_cmp++;
        if (sif.u_ready !== 1'b1 || sif.s_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: got ready %b valid %b want 1 0", sif.u_ready, sif.s_valid);
        end
    endtask

    task automatic test_back_to_back();
        int t [2]; logic [L-1:0] v [2]; int got = 0;
        sif.s_ready = 1'b1;
        for (int i = 0; i < 30 && sif.u_ready !== 1'b1; i++) tick();
        sif.u_data = 64'd15; sif.u_valid = 1'b1;
        tick();
        sif.u_data = 64'd45;
        for (int i = 0; i < 40 && got < 2; i++) begin
            tick();
            if (sif.s_valid === 1'b1) begin
                t[got] = cyc; v[got] = sif.s_index; got++;
                if (got == 2) sif.u_valid = 1'b0;
            end
        end
        sif.u_valid = 1'b0;
        tick();
        n_cmp++;
        if (got != 2 || v[0] !== 3'd1 || v[1] !== 3'd4) begin
            n_bad++; $display("FAIL b2b_values: got %0d samples %0d %0d want 2 samples 1 4", got, v[0], v[1]);
        end
        n_cmp++;
        if (got != 2 || t[1] - t[0] != 8) begin
            n_bad++; $display("FAIL b2b_period: got %0d want 8", t[1] - t[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [L-1:0] idx; logic [L:0] nz; bit ok; int seen = 0;
        sif.s_ready = 1'b1;
        for (int i = 0; i < 30 && sif.u_ready !== 1'b1; i++) tick();
        sif.u_data = 64'd60; sif.u_valid = 1'b1;
        tick();
        sif.u_valid = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || sif.mem_chipselect !== 1'b0) begin
            n_bad++; $display("FAIL mid_in_wait: got busy %b cs %b want 1 0", busy, sif.mem_chipselect);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sif.u_ready, sif.s_valid, sif.mem_chipselect, busy} !== 4'b0000 ||
            sif.s_index !== 3'd0 || sif.s_noise !== 4'hC || sif.mem_address !== BASE) begin
            n_bad++; $display("FAIL mid_reset_outputs: got ctl %b idx %0d noise %h addr %0d want 0000 0 c 100",
                              {sif.u_ready, sif.s_valid, sif.mem_chipselect, busy}, sif.s_index, sif.s_noise, sif.mem_address);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sif.s_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL mid_no_sample: got %0d valid cycles want 0", seen);
        end
        do_req(64'd55, 1'b1, lat, idx, nz, ok);
        n_cmp++;
        if (!ok || idx !== 3'd5) begin
            n_bad++; $display("FAIL mid_next_req: got ok %0d idx %0d want 5", ok, idx);
        end
    endtask

    task automatic test_random();
        int lat; logic [L-1:0] idx; logic [L:0] nz; bit ok;
        logic [63:0] u; int exp_i;
        sif.s_ready = 1'b1;
        bad_addr = 0;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 3))
                0: u = {$urandom, $urandom};
                1: u = 64'($urandom_range(0, 80));
                2: u = cdf[$urandom_range(0, 7)] + 64'($urandom_range(0, 2)) - 64'd1;
                default: u = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            endcase
            exp_i = ref_index(u);
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            rd_q.delete();
            do_req(u, 1'b1, lat, idx, nz, ok);
            n_cmp++;
            if (!ok || int'(idx) != exp_i || int'($signed(nz)) != exp_i - int'(C)) begin
                n_bad++; $display("FAIL rand_%0d: u %h got ok %0d idx %0d noise %0d want idx %0d", n, u, ok, idx, $signed(nz), exp_i);
            end
            n_cmp++;
            if (rd_q.size() != 3 || lat != 7) begin
                n_bad++; $display("FAIL rand_reads_%0d: got %0d reads lat %0d want 3 reads lat 7", n, rd_q.size(), lat);
            end
        end
        n_cmp++;
        if (bad_addr != 0 || wr_seen != 0) begin
            n_bad++; $display("FAIL rand_bus: got %0d bad addrs %0d writes want 0 0", bad_addr, wr_seen);
        end
    endtask

    initial begin
        cdf[0] = 64'd10; cdf[1] = 64'd20; cdf[2] = 64'd30; cdf[3] = 64'd40;
        cdf[4] = 64'd50; cdf[5] = 64'd60; cdf[6] = 64'd70; cdf[7] = 64'hFFFF_FFFF_FFFF_FFFF;
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
